spi_master_param: RTL and testbench
===================================

Name: spi_master_param

Overview:
Parametrised SPI master. Successor to the fixed 8-bit single-slave SPI master.
- Adds configurable word width, SCLK divider and number of active-low slave selects.
- Adds per-transfer MSB/LSB ordering and chip-select hold for back-to-back burst words.
- Sits between the AXI-Lite register slave and the off-chip SPI pins.

Parameters:
DATA_WIDTH, 8, bits per word (2..32)
CLK_DIV, 50, clk cycles per SCLK half-period (>=2)
NUM_SS, 4, number of slave-select outputs (1..8)
SS_W, $clog2(NUM_SS) (min 1), width of ss_sel

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-low reset (sampled on clk rising edge; 0 = reset)
cpol  in  1  clock polarity, latched at start
cpha  in  1  clock phase, latched at start
lsb_first  in  1  1 = LSB shifted first, latched at start
keep_cs  in  1  1 = hold slave select asserted after this word, latched at start
cs_release  in  1  ends a held burst
ss_sel  in  SS_W  target slave index, latched at start
start  in  1  transfer request, accepted only when ready=1
tx_data  in  DATA_WIDTH  word to send
rx_data  out  DATA_WIDTH  last received word
done  out  1  one-cycle pulse, word complete
ready  out  1  can accept start
busy  out  1  slave select asserted
SCLK  out  1  serial clock
MOSI  out  1  serial data out
MISO  in  1  serial data in
SS_N  out  NUM_SS  active-low slave selects

Behaviour:
- Reset (rst=0 at a clk edge), next cycle:
  - Registers: state=IDLE, latched cpol/cpha/lsb/keep=0, shift regs=0, counters=0, bit count=0.
  - Outputs: SS_N all 1, SCLK=0, MOSI=0, rx_data=0, done=0, ready=1, busy=0.
  - Reset mid-transfer aborts immediately with no done pulse.
- SCLK = latched_cpol XOR active.
  - active=1 in PH2 when cpha=0, and in PH1 when cpha=1; otherwise active=0.
- MOSI = tx_shift[DATA_WIDTH-1] when lsb=0, else tx_shift[0].
- IDLE:
  - ready=1.
  - start=1 latches all config inputs and tx_data; next state LEAD; ready drops the next cycle.
  - ss_sel >= NUM_SS: no SS_N bit asserted; the transfer still runs.
- LEAD: SS_N[sel]=0; lasts CLK_DIV cycles, then PH1.
- PH1: lasts CLK_DIV cycles. On the last cycle, sample MISO into rx_shift:
  - lsb=0: shift left, MISO into bit 0.
  - lsb=1: shift right, MISO into bit DATA_WIDTH-1.
- PH2: lasts CLK_DIV cycles. On the last cycle:
  - If bit count < DATA_WIDTH-1: shift tx_shift, increment bit count, go to PH1.
  - Else: rx_data <= rx_shift (including the final sampled bit), done=1 for that cycle; go to HOLD if keep=1, else TRAIL.
- HOLD:
  - SS_N[sel] stays 0; SCLK at idle level; ready=1.
  - start=1: latch only tx_data, lsb_first and keep_cs; cpol/cpha/ss_sel keep their latched values; go directly to PH1 (no LEAD).
  - cs_release=1 (with start=0): go to TRAIL. start has priority if both are asserted.
- TRAIL: SS_N[sel]=0 for CLK_DIV cycles, then IDLE with SS_N all 1.
- busy=1 in every state except IDLE.
- Word latency, start accepted to done:
  - From IDLE: CLK_DIV*(1 + 2*DATA_WIDTH) cycles.
  - From HOLD: 2*CLK_DIV*DATA_WIDTH cycles.
- Counters wrap to 0 at each phase end. bit count resets to 0 on every accepted start.
- start while ready=0 is ignored; no queuing.

Optional Feature:
- Macro SPI_MASTER_LOOPBACK_EN.
- When defined: adds input port loopback (1 bit). With loopback=1, the sampled serial input is MOSI instead of MISO; SCLK/SS_N behave normally.
- When undefined: no loopback port; MISO is always sampled.

Test Plan:
1. DATA_WIDTH=8, CLK_DIV=4, cpol=0, cpha=0, lsb_first=0, tx_data=0xA5, MISO driven from a slave model returning 0x3C:
   - MOSI bits 1,0,1,0,0,1,0,1 stable at each SCLK rise.
   - rx_data=0x3C; done high exactly 1 cycle, 68 cycles after start.
2. All four cpol/cpha combos, tx_data=0x81, slave echoes MOSI:
   - SCLK idle level = cpol; rx_data=0x81 in each mode.
3. lsb_first=1, tx_data=0x01, slave sends 0x80 LSB-first:
   - MOSI first bit 1, remaining bits 0.
   - rx_data=0x80.
4. keep_cs=1, three words 0x11,0x22,0x33 (keep_cs=0 on the last word), ss_sel=2:
   - SS_N=4'b1011 continuously across all words.
   - Three done pulses; 2nd and 3rd latency 64 cycles; SS_N=4'b1111 after TRAIL.
5. HOLD with cs_release=1 (start=0):
   - TRAIL of CLK_DIV cycles, then IDLE with ready=1 and SS_N all 1.
6. rst=0 asserted midway through bit 3:
   - Next cycle SS_N all 1, SCLK=0, rx_data=0, ready=1; no done pulse.

Source files
------------

// File: rtl/spi_master_param.sv
// Parametrised SPI master: configurable word width, SCLK divider, slave-select count,
// per-word bit order and chip-select hold for bursts. Optional macro: SPI_MASTER_LOOPBACK_EN.
module spi_master_param #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 50,
  parameter int NUM_SS     = 4,
  parameter int SS_W       = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  input  logic                  keep_cs,
  input  logic                  cs_release,
  input  logic [SS_W-1:0]       ss_sel,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  done,
  output logic                  ready,
  output logic                  busy,
  output logic                  SCLK,
  output logic                  MOSI,
  input  logic                  MISO,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic                  loopback,
`endif
  output logic [NUM_SS-1:0]     SS_N
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_PH1,
    S_PH2,
    S_HOLD,
    S_TRAIL
  } state_t;

  state_t                  state_q, state_d;
  logic                    cpol_q, cpol_d;
  logic                    cpha_q, cpha_d;
  logic                    lsb_q, lsb_d;
  logic                    keep_q, keep_d;
  logic [SS_W-1:0]         sel_q, sel_d;
  logic [DATA_WIDTH-1:0]   tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0]   rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic                    done_q, done_d;
  logic                    sclk_q, sclk_d;
  logic [NUM_SS-1:0]       ss_n_q, ss_n_d;
  logic                    phase_end;
  logic                    mosi_w;
  logic                    sin;

  assign mosi_w = lsb_q ? tx_shift_q[0] : tx_shift_q[DATA_WIDTH-1];

`ifdef SPI_MASTER_LOOPBACK_EN
  assign sin = loopback ? mosi_w : MISO;
`else
  assign sin = MISO;
`endif

  assign phase_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    lsb_d      = lsb_q;
    keep_d     = keep_q;
    sel_d      = sel_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    bit_d      = bit_q;
    done_d     = 1'b0;
    cnt_d      = phase_end ? '0 : cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          cpol_d     = cpol;
          cpha_d     = cpha;
          lsb_d      = lsb_first;
          keep_d     = keep_cs;
          sel_d      = ss_sel;
          tx_shift_d = tx_data;
          rx_shift_d = '0;
          bit_d      = '0;
          state_d    = S_LEAD;
        end
      end
      S_LEAD: begin
        if (phase_end) state_d = S_PH1;
      end
      S_PH1: begin
        if (phase_end) begin
          rx_shift_d = lsb_q ? {sin, rx_shift_q[DATA_WIDTH-1:1]}
                             : {rx_shift_q[DATA_WIDTH-2:0], sin};
          state_d    = S_PH2;
        end
      end
      S_PH2: begin
        if (phase_end) begin
          if (bit_q != BIT_LAST) begin
            tx_shift_d = lsb_q ? (tx_shift_q >> 1) : (tx_shift_q << 1);
            bit_d      = bit_q + BIT_W'(1);
            state_d    = S_PH1;
          end else begin
            rx_data_d = rx_shift_q;
            done_d    = 1'b1;
            state_d   = keep_q ? S_HOLD : S_TRAIL;
          end
        end
      end
      S_HOLD: begin
        cnt_d = '0;
        // Burst continuation keeps clock mode and target; only word, order and hold change.
        if (start) begin
          lsb_d      = lsb_first;
          keep_d     = keep_cs;
          tx_shift_d = tx_data;
          rx_shift_d = '0;
          bit_d      = '0;
          state_d    = S_PH1;
        end else if (cs_release) begin
          state_d = S_TRAIL;
        end
      end
      S_TRAIL: begin
        if (phase_end) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Pin outputs are decoded from the next state so they leave the flops glitch-free.
    sclk_d = cpol_d ^ (((state_d == S_PH2) && !cpha_d) || ((state_d == S_PH1) && cpha_d));
    ss_n_d = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if ((state_d != S_IDLE) && (sel_d == SS_W'(i))) ss_n_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      keep_q     <= 1'b0;
      sel_q      <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      cnt_q      <= '0;
      bit_q      <= '0;
      done_q     <= 1'b0;
      sclk_q     <= 1'b0;
      ss_n_q     <= '1;
    end else begin
      state_q    <= state_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      lsb_q      <= lsb_d;
      keep_q     <= keep_d;
      sel_q      <= sel_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      done_q     <= done_d;
      sclk_q     <= sclk_d;
      ss_n_q     <= ss_n_d;
    end
  end

  assign rx_data = rx_data_q;
  assign done    = done_q;
  assign ready   = (state_q == S_IDLE) || (state_q == S_HOLD);
  assign busy    = (state_q != S_IDLE);
  assign SCLK    = sclk_q;
  assign MOSI    = mosi_w;
  assign SS_N    = ss_n_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: directed steps plus random words against an edge-counting SPI slave model.
module tb_spi_master_param;
  localparam int DW = 8;
  localparam int CD = 4;
  localparam int NS = 4;
  localparam int SW = 2;
  localparam int LAT_IDLE = CD * (1 + 2 * DW);
  localparam int LAT_HOLD = 2 * CD * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0, keep_cs = 1'b0;
  logic          cs_release = 1'b0, start = 1'b0;
  logic [SW-1:0] ss_sel = '0;
  logic [DW-1:0] tx_data = '0;
  logic [DW-1:0] rx_data;
  logic          done, ready, busy, SCLK, MOSI, MISO;
  logic [NS-1:0] SS_N;

  int total = 0;
  int bad = 0;

  // slave model state
  logic       slv_cpol = 1'b0, slv_cpha = 1'b0, slv_lsb = 1'b0, echo = 1'b0;
  logic [7:0] slv_q[$];
  logic       mosi_bits[$];
  int         lead_cnt = 0, trail_cnt = 0;
  logic       sclk_prev = 1'b0, ss_act_prev = 1'b0, slave_bit = 1'b0;
  int         done_seen = 0;
  logic       ss_watch = 1'b0;
  logic [3:0] ss_exp = 4'hF;
  int         ss_err = 0;

  always #5 clk = ~clk;

  spi_master_param #(.DATA_WIDTH(DW), .CLK_DIV(CD), .NUM_SS(NS)) dut (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .keep_cs(keep_cs), .cs_release(cs_release), .ss_sel(ss_sel), .start(start),
    .tx_data(tx_data), .rx_data(rx_data), .done(done), .ready(ready), .busy(busy),
    .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .SS_N(SS_N)
  );

  assign MISO = echo ? MOSI : slave_bit;

  // Slave: counts leading/trailing SCLK edges while selected; presents bit N of its word stream
  // after N shift edges and records MOSI on every capture edge.
  always @(negedge clk) begin : slave
    int nl, nt, idx;
    logic [7:0] w;
    nl = lead_cnt;
    nt = trail_cnt;
    if (SS_N == '1) begin
      nl = 0;
      nt = 0;
    end else if (ss_act_prev && (SCLK != sclk_prev)) begin
      if (SCLK != slv_cpol) begin
        nl = nl + 1;
        if (!slv_cpha) mosi_bits.push_back(MOSI);
      end else begin
        nt = nt + 1;
        if (slv_cpha) mosi_bits.push_back(MOSI);
      end
    end
    idx = slv_cpha ? nl - 1 : nt;
    if (idx < 0) idx = 0;
    w = ((idx / 8) < slv_q.size()) ? slv_q[idx / 8] : 8'h00;
    slave_bit   <= slv_lsb ? w[idx % 8] : w[7 - (idx % 8)];
    lead_cnt    <= nl;
    trail_cnt   <= nt;
    sclk_prev   <= SCLK;
    ss_act_prev <= (SS_N != '1);
  end

  always @(negedge clk) begin
    if (done === 1'b1) done_seen <= done_seen + 1;
    if (ss_watch && busy && (SS_N !== ss_exp)) ss_err <= ss_err + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while ((ready !== 1'b1) && (n < 100)) begin
      tick();
      n++;
    end
    chk({tag, ":ready"}, {31'd0, ready}, 32'd1);
  endtask

  // One word: drives start, checks select, latency, single-cycle done, rx word and MOSI stream.
  task automatic xfer(input string tag, input logic [7:0] tx, input logic cp, input logic ch,
                      input logic lsb, input logic keep, input logic [1:0] sel,
                      input int exp_lat, input logic [7:0] exp_rx);
    int lat;
    bit got;
    logic [7:0] mw;
    logic [3:0] ess;
    ess = ~(4'b0001 << sel);
    slv_cpol = cp;
    slv_cpha = ch;
    slv_lsb = lsb;
    mosi_bits.delete();
    cpol = cp; cpha = ch; lsb_first = lsb; keep_cs = keep; ss_sel = sel; tx_data = tx;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, ":ss"}, {28'd0, SS_N}, {28'd0, ess});
    chk({tag, ":ready_low"}, {31'd0, ready}, 32'd0);
    lat = 0;
    got = 0;
    while (!got && (lat < 400)) begin
      tick();
      lat++;
      if (done === 1'b1) got = 1;
    end
    chk({tag, ":latency"}, lat, exp_lat);
    chk({tag, ":rx"}, {24'd0, rx_data}, {24'd0, exp_rx});
    mw = '0;
    foreach (mosi_bits[i]) begin
      if (i < 8) begin
        if (lsb) mw[i] = mosi_bits[i];
        else mw[7 - i] = mosi_bits[i];
      end
    end
    chk({tag, ":mosi_bits"}, mosi_bits.size(), 8);
    chk({tag, ":mosi_word"}, {24'd0, mw}, {24'd0, tx});
    tick();
    chk({tag, ":done_1cyc"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [7:0] w0, w1, w2, rtx, rsw;
    logic rcp, rch, rlsb;
    logic [1:0] rsel;
    int dc0;

    // reset state
    repeat (3) tick();
    chk("rst:ss_n", {28'd0, SS_N}, 32'hF);
    chk("rst:sclk", {31'd0, SCLK}, 32'd0);
    chk("rst:mosi", {31'd0, MOSI}, 32'd0);
    chk("rst:rx", {24'd0, rx_data}, 32'd0);
    chk("rst:done", {31'd0, done}, 32'd0);
    chk("rst:ready", {31'd0, ready}, 32'd1);
    chk("rst:busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    tick();

    // mode 0, MSB first, slave returns 0x3C
    echo = 1'b0;
    slv_q = {8'h3C};
    xfer("t1", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, LAT_IDLE, 8'h3C);

    // all four clock modes with the slave echoing MOSI
    echo = 1'b1;
    for (int m = 0; m < 4; m++) begin
      wait_ready("t2");
      xfer("t2", 8'h81, m[1], m[0], 1'b0, 1'b0, 2'd3, LAT_IDLE, 8'h81);
      wait_ready("t2_end");
      chk("t2:sclk_idle", {31'd0, SCLK}, {31'd0, m[1]});
    end
    echo = 1'b0;

    // LSB first
    wait_ready("t3");
    slv_q = {8'h80};
    xfer("t3", 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, LAT_IDLE, 8'h80);
    chk("t3:first_bit", {31'd0, mosi_bits[0]}, 32'd1);

    // three-word burst on slave 2 with chip select held
    wait_ready("t4");
    w0 = 8'($urandom); w1 = 8'($urandom); w2 = 8'($urandom);
    slv_q = {w0, w1, w2};
    ss_exp = 4'b1011;
    ss_err = 0;
    ss_watch = 1'b1;
    xfer("t4w0", 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, LAT_IDLE, w0);
    xfer("t4w1", 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, LAT_HOLD, w1);
    xfer("t4w2", 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, LAT_HOLD, w2);
    tick();
    tick();
    chk("t4:trail_ss", {28'd0, SS_N}, 32'hB);
    tick();
    ss_watch = 1'b0;
    chk("t4:ss_continuous", ss_err, 0);
    chk("t4:end_ss", {28'd0, SS_N}, 32'hF);
    chk("t4:end_ready", {31'd0, ready}, 32'd1);

    // hold then release without a further word
    wait_ready("t5");
    rsw = 8'($urandom);
    slv_q = {rsw};
    xfer("t5", 8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, LAT_IDLE, rsw);
    chk("t5:hold_ready", {31'd0, ready}, 32'd1);
    chk("t5:hold_busy", {31'd0, busy}, 32'd1);
    chk("t5:hold_ss", {28'd0, SS_N}, 32'hD);
    chk("t5:hold_sclk", {31'd0, SCLK}, 32'd1);
    cs_release = 1'b1;
    tick();
    cs_release = 1'b0;
    chk("t5:trail_ready", {31'd0, ready}, 32'd0);
    repeat (3) tick();
    chk("t5:trail_ss", {28'd0, SS_N}, 32'hD);
    tick();
    chk("t5:idle_ss", {28'd0, SS_N}, 32'hF);
    chk("t5:idle_ready", {31'd0, ready}, 32'd1);
    chk("t5:idle_busy", {31'd0, busy}, 32'd0);

    // random words, modes, orders and targets
    for (int k = 0; k < 5; k++) begin
      wait_ready("rnd");
      rtx = 8'($urandom);
      rsw = 8'($urandom);
      rcp = 1'($urandom);
      rch = 1'($urandom);
      rlsb = 1'($urandom);
      rsel = 2'($urandom);
      slv_q = {rsw};
      xfer("rnd", rtx, rcp, rch, rlsb, 1'b0, rsel, LAT_IDLE, rsw);
    end

    // reset in the middle of bit 3
    wait_ready("t6");
    slv_q = {8'hC3};
    cpol = 1'b1; cpha = 1'b0; lsb_first = 1'b0; keep_cs = 1'b0; ss_sel = 2'd0;
    slv_cpol = 1'b1; slv_cpha = 1'b0; slv_lsb = 1'b0;
    tx_data = 8'($urandom);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (30) tick();
    chk("t6:pre_sclk", {31'd0, SCLK}, 32'd1);
    dc0 = done_seen;
    rst = 1'b0;
    tick();
    chk("t6:ss_n", {28'd0, SS_N}, 32'hF);
    chk("t6:sclk", {31'd0, SCLK}, 32'd0);
    chk("t6:rx", {24'd0, rx_data}, 32'd0);
    chk("t6:ready", {31'd0, ready}, 32'd1);
    chk("t6:busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    repeat (100) tick();
    chk("t6:no_done", done_seen, dc0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
